pic_priority_core: RTL and testbench

Parametrised, clocked priority resolution and in-service core for the PIC. It resolves the highest-priority unmasked request in `N` channels under fully nested, automatic-rotation, specific-rotation and special-mask modes. It owns the In-Service Register, the rotation pointer and EOI processing, and sits between the IRR/IMR registers and the INTA/control sequencer.

---
 rtl/pic_priority_core.sv | 93 +++++++++
 tb/tb_pic_priority_core.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pic_priority_core.sv
// pic_priority_core: rotating-priority resolver with in-service register, rotation pointer and EOI handling
//   clk, rst_n                                 clock, asynchronous active-low reset
//   irr, imr                                   pending requests, mask (1 = masked)
//   special_mask, aeoi, auto_rotate            mode controls
//   inta                                       accept the current winner
//   eoi, eoi_specific, eoi_rotate, eoi_level   end-of-interrupt command
//   set_prio, prio_level                       make prio_level the lowest-priority channel
//   int_out, vec, spurious, irr_clr            CPU request, accepted channel, spurious ack, IRR clear
//   isr, lowest                                in-service register, current lowest-priority channel
module pic_priority_core #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] irr,
  input  logic [N-1:0] imr,
  input  logic         special_mask,
  input  logic         aeoi,
  input  logic         auto_rotate,
  input  logic         inta,
  input  logic         eoi,
  input  logic         eoi_specific,
  input  logic         eoi_rotate,
  input  logic [W-1:0] eoi_level,
  input  logic         set_prio,
  input  logic [W-1:0] prio_level,
  output logic         int_out,
  output logic [W-1:0] vec,
  output logic         spurious,
  output logic [N-1:0] irr_clr,
  output logic [N-1:0] isr,
  output logic [W-1:0] lowest
);
  logic [N-1:0] cand, eoi_clr, isr_set;
  logic [W-1:0] win_ch, top_isr_ch, eoi_ch;
  int win_pos, isr_pos;
  logic valid, eoi_hit, eoi_rot, aeoi_rot, prio_ok;

  // Channel sitting at priority position i (0 = highest), wrapping modulo N.
  function automatic logic [W-1:0] ch_at(input logic [W-1:0] low, input int i);
    int c;
    c = int'(low) + 1 + i;
    return W'(c >= N ? c - N : c);
  endfunction

  // Scan from lowest to highest priority so the highest-priority hit is the one kept.
  // A position of N means nothing was found.
  always_comb begin
    cand = irr & ~imr & ~(special_mask ? isr : '0);
    win_pos = N;
    win_ch = '0;
    isr_pos = N;
    top_isr_ch = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[ch_at(lowest, i)]) begin
        win_pos = i;
        win_ch = ch_at(lowest, i);
      end
      if (isr[ch_at(lowest, i)]) begin
        isr_pos = i;
        top_isr_ch = ch_at(lowest, i);
      end
    end
  end

  // Fully nested: winner must outrank every in-service channel; special mask ignores isr.
  assign valid    = win_pos < N && (special_mask || win_pos < isr_pos);
  assign eoi_hit  = eoi && (eoi_specific ? int'(eoi_level) < N : isr_pos < N);
  assign eoi_ch   = eoi_specific ? eoi_level : top_isr_ch;
  assign eoi_clr  = eoi_hit ? N'(1) << eoi_ch : '0;
  assign isr_set  = inta && valid && !aeoi ? N'(1) << win_ch : '0;
  assign prio_ok  = set_prio && int'(prio_level) < N;
  assign eoi_rot  = eoi_hit && eoi_rotate;
  assign aeoi_rot = inta && valid && aeoi && auto_rotate;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      isr      <= '0;
      lowest   <= W'(N - 1);
      vec      <= '0;
      int_out  <= 1'b0;
      spurious <= 1'b0;
      irr_clr  <= '0;
    end else begin
      isr      <= (isr & ~eoi_clr) | isr_set;
      lowest   <= prio_ok ? prio_level : eoi_rot ? eoi_ch : aeoi_rot ? win_ch : lowest;
      vec      <= inta ? (valid ? win_ch : W'(N - 1)) : vec;
      int_out  <= valid;
      spurious <= inta && !valid;
      irr_clr  <= inta && valid ? N'(1) << win_ch : '0;
    end
endmodule

// File: tb/tb_pic_priority_core.sv
// tb_pic_priority_core: directed checks of the priority core at N=8 and N=5
module tb_pic_priority_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_irr = '0, a_imr = '0, a_irr_clr, a_isr;
  logic a_sm = 0, a_aeoi = 0, a_arot = 0, a_inta = 0, a_eoi = 0, a_eoi_spec = 0, a_eoi_rot = 0, a_set_prio = 0;
  logic [2:0] a_eoi_level = '0, a_prio_level = '0, a_vec, a_lowest;
  logic a_int_out, a_spurious;

  logic [4:0] b_irr = '0, b_imr = '0, b_irr_clr, b_isr;
  logic b_inta = 0, b_eoi = 0, b_eoi_spec = 0, b_eoi_rot = 0, b_set_prio = 0;
  logic [2:0] b_eoi_level = '0, b_prio_level = '0, b_vec, b_lowest;
  logic b_int_out, b_spurious;

  int total = 0, bad = 0;

  pic_priority_core #(.N(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .irr(a_irr), .imr(a_imr), .special_mask(a_sm), .aeoi(a_aeoi),
    .auto_rotate(a_arot), .inta(a_inta), .eoi(a_eoi), .eoi_specific(a_eoi_spec), .eoi_rotate(a_eoi_rot),
    .eoi_level(a_eoi_level), .set_prio(a_set_prio), .prio_level(a_prio_level), .int_out(a_int_out),
    .vec(a_vec), .spurious(a_spurious), .irr_clr(a_irr_clr), .isr(a_isr), .lowest(a_lowest)
  );

  pic_priority_core #(.N(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .irr(b_irr), .imr(b_imr), .special_mask(1'b0), .aeoi(1'b0),
    .auto_rotate(1'b0), .inta(b_inta), .eoi(b_eoi), .eoi_specific(b_eoi_spec), .eoi_rotate(b_eoi_rot),
    .eoi_level(b_eoi_level), .set_prio(b_set_prio), .prio_level(b_prio_level), .int_out(b_int_out),
    .vec(b_vec), .spurious(b_spurious), .irr_clr(b_irr_clr), .isr(b_isr), .lowest(b_lowest)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    a_inta = 0; a_eoi = 0; a_set_prio = 0; a_eoi_spec = 0; a_eoi_rot = 0;
    b_inta = 0; b_eoi = 0; b_set_prio = 0; b_eoi_spec = 0; b_eoi_rot = 0;
  endtask

  initial begin
    #12;
    chk("rst_isr", a_isr, 8'h00);
    chk("rst_lowest", a_lowest, 7);
    chk("rst_vec", a_vec, 0);
    chk("rst_int", a_int_out, 0);
    chk("rst_spur", a_spurious, 0);
    chk("rst_clr", a_irr_clr, 0);
    chk("rst_lowest5", b_lowest, 4);
    @(negedge clk);
    rst_n = 1;
    tick;
    a_irr = 8'hA4;
    tick;
    chk("fn_int", a_int_out, 1);
    a_inta = 1;
    tick;
    chk("fn_vec", a_vec, 2);
    chk("fn_isr", a_isr, 8'h04);
    chk("fn_clr", a_irr_clr, 8'h04);
    a_irr = 8'hA0;
    tick;
    chk("fn_clr_pulse", a_irr_clr, 8'h00);
    chk("fn_blocked", a_int_out, 0);
    a_eoi = 1; a_eoi_spec = 1; a_eoi_level = 2;
    tick;
    chk("seoi_isr", a_isr, 8'h00);
    a_irr = 8'h20; a_inta = 1;
    tick;
    chk("nest_isr5", a_isr, 8'h20);
    a_irr = 8'h08;
    tick;
    chk("nest_int", a_int_out, 1);
    a_inta = 1;
    tick;
    chk("nest_vec", a_vec, 3);
    chk("nest_isr", a_isr, 8'h28);
    a_irr = 8'h00; a_eoi = 1;
    tick;
    chk("nseoi_isr", a_isr, 8'h20);
    a_eoi = 1;
    tick;
    chk("nseoi_isr2", a_isr, 8'h00);
    a_aeoi = 1; a_arot = 1; a_irr = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      a_inta = 1;
      tick;
      chk("arot_vec", a_vec, k % 8);
      chk("arot_lowest", a_lowest, k % 8);
      chk("arot_isr", a_isr, 8'h00);
    end
    a_aeoi = 0; a_arot = 0; a_irr = 8'h00;
    a_set_prio = 1; a_prio_level = 4;
    tick;
    chk("sprio_lowest", a_lowest, 4);
    a_irr = 8'h21; a_inta = 1;
    tick;
    chk("sprio_vec", a_vec, 5);
    chk("sprio_isr", a_isr, 8'h20);
    a_irr = 8'h00; a_inta = 1;
    tick;
    chk("spur_vec", a_vec, 7);
    chk("spur_pulse", a_spurious, 1);
    chk("spur_clr", a_irr_clr, 8'h00);
    chk("spur_isr", a_isr, 8'h20);
    a_eoi = 1; a_eoi_spec = 1; a_eoi_level = 5;
    tick;
    chk("spur_pulse_end", a_spurious, 0);
    chk("seoi5_isr", a_isr, 8'h00);
    a_set_prio = 1; a_prio_level = 7;
    tick;
    a_irr = 8'h01; a_inta = 1; a_eoi = 1; a_eoi_spec = 1; a_eoi_level = 0;
    tick;
    chk("coll_set_wins", a_isr, 8'h01);
    a_irr = 8'h80;
    tick;
    chk("fnest_block", a_int_out, 0);
    a_sm = 1;
    tick;
    chk("smm_int", a_int_out, 1);
    a_inta = 1; a_eoi = 1; a_eoi_spec = 1; a_eoi_level = 0;
    tick;
    chk("smm_isr", a_isr, 8'h80);
    chk("smm_vec", a_vec, 7);
    a_sm = 0; a_irr = 8'h00;
    a_eoi = 1; a_eoi_spec = 1; a_eoi_rot = 1; a_eoi_level = 7; a_set_prio = 1; a_prio_level = 2;
    tick;
    chk("prio_over_eoi", a_lowest, 2);
    chk("prio_eoi_isr", a_isr, 8'h00);
    a_eoi = 1; a_eoi_spec = 1; a_eoi_rot = 1; a_eoi_level = 3;
    tick;
    chk("seoi_rot", a_lowest, 3);
    a_irr = 8'h01; a_inta = 1;
    tick;
    chk("wrap_isr", a_isr, 8'h01);
    a_irr = 8'h00; a_eoi = 1; a_eoi_rot = 1;
    tick;
    chk("nseoi_rot", a_lowest, 0);
    chk("nseoi_rot_isr", a_isr, 8'h00);
    b_set_prio = 1; b_prio_level = 6;
    tick;
    chk("n5_prio_oor", b_lowest, 4);
    b_irr = 5'b10000; b_inta = 1;
    tick;
    chk("n5_vec", b_vec, 4);
    chk("n5_isr", b_isr, 5'b10000);
    b_irr = '0; b_eoi = 1; b_eoi_spec = 1; b_eoi_level = 7;
    tick;
    chk("n5_eoi_oor", b_isr, 5'b10000);
    b_eoi = 1; b_eoi_spec = 1; b_eoi_level = 4;
    tick;
    chk("n5_eoi4", b_isr, 5'b00000);
    b_set_prio = 1; b_prio_level = 2;
    tick;
    chk("n5_lowest2", b_lowest, 2);
    b_irr = 5'b00011; b_inta = 1;
    tick;
    chk("n5_wrap_vec", b_vec, 0);
    b_irr = '0;
    b_eoi = 1;
    tick;
    b_inta = 1;
    tick;
    chk("n5_spur_vec", b_vec, 4);
    chk("n5_spur", b_spurious, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
